// File: rtl/scc_mem_pkg.sv
// rtl/scc_mem_pkg.sv - shared types and defaults for the SCC memory arbiter
package scc_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_MEM_LAT    = 2;
   localparam int DEF_STARVE_MAX = 4;

   localparam int ERR_WITHDRAW = 0;
   localparam int ERR_MISALIGN = 1;

endpackage

// File: rtl/scc_lat_pipe.sv
// rtl/scc_lat_pipe.sv - owner-tag shift register matching the memory read latency
module scc_lat_pipe
   import scc_mem_pkg::*;
#(
   parameter int DEPTH = DEF_MEM_LAT
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_owner,
   output logic [1:0] o_tail
);

   owner_t r_tag [DEPTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_tag[i] <= OWN_NONE;
      end else if (i_en) begin
         r_tag[0] <= owner_t'(i_owner);
         for (int i = 1; i < DEPTH; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign o_tail = r_tag[DEPTH-1];

endmodule

// File: rtl/scc_mem_arbiter.sv
// rtl/scc_mem_arbiter.sv - fetch/data arbiter for one fixed-latency memory port
module scc_mem_arbiter
   import scc_mem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clk_en,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic              o_if_gnt,
   output logic              o_if_rvalid,
   output logic [DATA_W-1:0] o_if_rdata,
   input  logic              i_dm_req,
   input  logic              i_dm_we,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   output logic              o_dm_gnt,
   output logic              o_dm_rvalid,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [1:0]        o_err_bits
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] r_starve_cnt;
   logic             r_if_wait;
   logic             r_dm_wait;
   logic [1:0]       r_err;

   logic             w_en;
   logic             w_if_prio;
   logic             w_if_gnt;
   logic             w_dm_gnt;
   logic [1:0]       w_owner_in;
   logic [1:0]       w_tail;

   assign w_en      = i_clk_en & ~i_rst;
   assign w_if_prio = (r_starve_cnt == CNT_W'(STARVE_MAX));
   assign w_if_gnt  = w_en & i_if_req & (~i_dm_req | w_if_prio);
   assign w_dm_gnt  = w_en & i_dm_req & ~w_if_gnt;

   // Stores never return data, so they occupy their pipeline slot as NONE.
   assign w_owner_in = w_if_gnt                ? 2'(OWN_IF) :
                       (w_dm_gnt & ~i_dm_we)   ? 2'(OWN_DM) : 2'(OWN_NONE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_starve_cnt <= '0;
         r_if_wait    <= 1'b0;
         r_dm_wait    <= 1'b0;
         r_err        <= 2'b00;
      end else if (i_clk_en) begin
         if (w_if_gnt | ~i_if_req) r_starve_cnt <= '0;
         else if (w_dm_gnt)        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         r_if_wait <= i_if_req & ~w_if_gnt;
         r_dm_wait <= i_dm_req & ~w_dm_gnt;
         if ((r_if_wait & ~i_if_req) | (r_dm_wait & ~i_dm_req)) r_err[ERR_WITHDRAW] <= 1'b1;
         if (w_dm_gnt & (|i_dm_addr[1:0]))                       r_err[ERR_MISALIGN] <= 1'b1;
      end
   end

   scc_lat_pipe #(
      .DEPTH (MEM_LAT)
   ) u_lat_pipe (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_clk_en),
      .i_owner (w_owner_in),
      .o_tail  (w_tail)
   );

   assign o_if_gnt    = w_if_gnt;
   assign o_dm_gnt    = w_dm_gnt;
   assign o_mem_en    = w_if_gnt | w_dm_gnt;
   assign o_mem_we    = w_dm_gnt & i_dm_we;
   assign o_mem_addr  = w_if_gnt ? i_if_addr : (w_dm_gnt ? i_dm_addr : '0);
   assign o_mem_wdata = w_dm_gnt ? i_dm_wdata : '0;
   assign o_if_rvalid = (w_tail == 2'(OWN_IF));
   assign o_dm_rvalid = (w_tail == 2'(OWN_DM));
   assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
   assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;
   assign o_err_bits  = r_err;

endmodule

// File: doc/scc_mem_arbiter.md
# scc_mem_arbiter

Single-port memory arbiter for the SCC core. It shares one synchronous, fixed-latency unified memory between the instruction-fetch port and the data load/store port. It issues at most one access per enabled cycle and tracks in-flight reads in a latency pipeline, so each read response returns to the requester that issued it. It sits between the core and the memory inside the top level, and it reports protocol and alignment faults on sticky error bits.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 32, data word width
- MEM_LAT, 2, enabled cycles from memory issue to mem_rdata valid (≥1)
- STARVE_MAX, 4, consecutive denied IF-request cycles before IF gets priority
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clk_en  in  1  global enable; 0 freezes all state and blocks issue
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch issued this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data access issued this cycle
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT enabled cycles after mem_en
- err_bits  out  2  sticky: [0] request withdrawn before grant, [1] misaligned dm_addr

## Operation
- **Issue:** combinational in the same cycle. Issue happens only when clk_en=1 and rst=0.
- **Default priority:** DM wins over IF.
- **Starvation guard:**
  - starve_cnt counts cycles where if_req=1 and the grant went to DM.
  - When starve_cnt == STARVE_MAX, IF wins the next contended cycle.
  - starve_cnt clears on any if_gnt, and when if_req=0.
- **Memory port:** mem_en = if_gnt | dm_gnt. mem_we = dm_gnt & dm_we. mem_addr and mem_wdata are muxed from the winner. When idle, mem_addr and mem_wdata are 0.
- **Tag pipeline:**
  - Depth MEM_LAT; each entry holds an owner ∈ {NONE, IF, DM}.
  - On an enabled cycle, it shifts in: IF for an if_gnt, DM for a load dm_gnt, NONE otherwise (stores push NONE).
  - The tail owner drives rvalid: if_rvalid = tail==IF, dm_rvalid = tail==DM.
  - mem_rdata passes to both rdata outputs. Each rdata output is 0 when its rvalid=0.
- **Errors:**
  - err_bits[0] sets if a req falls while it is not granted.
  - err_bits[1] sets on a dm_gnt with dm_addr[1:0] != 0. The access still issues.
  - Both bits clear only on rst.
- **Backpressure:** none. Requesters accept rvalid unconditionally.

## Timing
- **Reset:**
  - Asynchronous, active-high.
  - Clears the tag pipeline to NONE, starve_cnt to 0, and err_bits to 0.
  - While rst=1, all outputs are 0.
- **Grant latency:** 0 cycles from req to gnt when the requester wins.
- **Read latency:** rvalid appears exactly MEM_LAT enabled cycles after gnt. Back-to-back reads give one rvalid per cycle, in issue order.
- **clk_en=0:**
  - No gnt and no mem_en.
  - The pipeline, starve_cnt and err_bits hold.
  - rvalid outputs stay at their frozen tail value, and the memory is equally frozen.
- **Simultaneous requests:** exactly one gnt per cycle, never both.
- **starve_cnt at STARVE_MAX with if_req=1:** if_gnt is asserted regardless of dm_req.
- **rst mid-flight:** in-flight reads are discarded. No rvalid fires after reset for reads issued before it.

## Structure
- Package scc_mem_pkg:
  - owner enum (OWN_NONE, OWN_IF, OWN_DM)
  - default ADDR_W, DATA_W, MEM_LAT
  - err_bits index constants ERR_WITHDRAW=0, ERR_MISALIGN=1
- Sub-module scc_lat_pipe: parameterised owner-tag shift register (depth MEM_LAT, enable, async reset).
- Arbiter, starvation counter and error logic stay in scc_mem_arbiter.

## Test plan
- **IF-only read:** if_req=1, if_addr=0x0010, MEM_LAT=2, mem_rdata=0xDEADBEEF → if_gnt and mem_en in cycle 0, mem_addr=0x0010, if_rvalid with if_rdata=0xDEADBEEF in cycle 2, dm_rvalid=0 throughout.
- **Contention:** if_req=dm_req=1 held continuously (dm loads) → dm_gnt for 4 cycles, if_gnt on the 5th, then dm_gnt for 4 more, repeating.
- **Store:** dm_req=1, dm_we=1, dm_addr=0x0104, dm_wdata=0x12345678 → dm_gnt, mem_we=1, mem_wdata=0x12345678, no dm_rvalid ever.
- **Mixed stream:** IF, DM-load, store, IF issued back-to-back → rvalid sequence IF, DM, none, IF at cycles 2–5, with owner matching.
- **Freeze:** clk_en=0 for 3 cycles right after an IF grant → if_rvalid arrives at cycle 5 instead of 2, no grants during the freeze.
- **Faults and reset:**
  - dm_addr=0x0102 granted → err_bits=2'b10.
  - if_req dropped while DM is granted → err_bits[0]=1.
  - rst pulsed with reads in flight → err_bits=0, and no rvalid afterwards.
